// File: rtl/band_scale_seq.sv
// Multi-band gain stage: one shared squarer/multiplier walks the bands in turn,
// then all saturated results are published to the outputs together.
module band_scale_seq #(
    parameter int NUM_BANDS = 5,
    parameter int AUD_W     = 16,
    parameter int POT_W     = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          strt,
    input  logic [NUM_BANDS*POT_W-1:0]    POT,
    input  logic [NUM_BANDS*AUD_W-1:0]    audio,
    output logic [NUM_BANDS*AUD_W-1:0]    scaled,
    output logic                          busy,
    output logic                          valid
);
    localparam int PW    = POT_W + 1 + AUD_W;
    localparam int H     = AUD_W + POT_W - 3;
    localparam int L     = POT_W - 2;
    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SQR, S_MUL, S_SAT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [POT_W-1:0]         pot_q    [NUM_BANDS];
    logic signed [AUD_W-1:0]  aud_q    [NUM_BANDS];
    logic [AUD_W-1:0]         shadow_q [NUM_BANDS];
    logic [AUD_W-1:0]         scaled_q [NUM_BANDS];
    logic [POT_W-1:0]         gain_q;
    logic signed [PW-1:0]     prod_q;
    logic                     busy_q, valid_q;

    logic                     start_ok;
    logic [POT_W-1:0]         pot_cur;
    logic signed [AUD_W-1:0]  aud_cur;
    logic [2*POT_W-1:0]       sq;
    logic [POT_W-1:0]         gain_c;
    logic signed [PW-1:0]     gain_ext, aud_ext, prod_c;
    logic [AUD_W-1:0]         sat_c;

    // A strt landing in the valid cycle must not start a pass.
    assign start_ok = strt && (state_q == S_IDLE) && !valid_q;

    assign pot_cur  = pot_q[idx_q];
    assign aud_cur  = aud_q[idx_q];
    assign sq       = {{POT_W{1'b0}}, pot_cur} * {{POT_W{1'b0}}, pot_cur};
    assign gain_c   = POT_W'(sq >> POT_W);
    assign gain_ext = $signed({{AUD_W{1'b0}}, 1'b0, gain_q});
    assign aud_ext  = {{(POT_W+1){aud_cur[AUD_W-1]}}, aud_cur};
    assign prod_c   = gain_ext * aud_ext;

    // Result window is product[H:L]; anything above it must be pure sign extension.
    always_comb begin
        sat_c = AUD_W'(prod_q >>> L);
        if (prod_q[PW-1] && !(&prod_q[PW-2:H])) begin
            sat_c = {1'b1, {(AUD_W-1){1'b0}}};
        end else if (!prod_q[PW-1] && (|prod_q[PW-2:H])) begin
            sat_c = {1'b0, {(AUD_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_SQR;
                    idx_d   = '0;
                end
            end
            S_SQR: state_d = S_MUL;
            S_MUL: state_d = S_SAT;
            S_SAT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SQR;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gain_q  <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                pot_q[b]    <= '0;
                aud_q[b]    <= '0;
                shadow_q[b] <= '0;
                scaled_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= (state_q == S_DONE);
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (state_q == S_DONE) begin
                busy_q <= 1'b0;
            end
            if (state_q == S_SQR) begin
                gain_q <= gain_c;
            end
            if (state_q == S_MUL) begin
                prod_q <= prod_c;
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (start_ok) begin
                    pot_q[b] <= POT[b*POT_W +: POT_W];
                    aud_q[b] <= audio[b*AUD_W +: AUD_W];
                end
                if ((state_q == S_SAT) && (idx_q == IDX_W'(b))) begin
                    shadow_q[b] <= sat_c;
                end
                if (state_q == S_DONE) begin
                    scaled_q[b] <= shadow_q[b];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_out
        assign scaled[gi*AUD_W +: AUD_W] = scaled_q[gi];
    end

    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: doc/band_scale_seq.md
Name: band_scale_seq

Overview:
- Parametrised, sequential successor to the single-band combinational scaler in the equalizer datapath.
- Scales NUM_BANDS band-filter outputs by squared-POT gains using one shared squarer/multiplier, time-multiplexed by an FSM.
- Sits between the band FIR outputs and the band summer.
- Start/valid handshake per audio sample; atomic, saturated output update.

Parameters:
- NUM_BANDS, 5, number of bands processed per start.
- AUD_W, 16, signed audio sample width.
- POT_W, 12, unsigned POT width (must be >= 3).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- strt  input  1  one-cycle pulse: capture inputs and begin a pass; ignored while busy.
- POT  input  NUM_BANDS*POT_W  unsigned gains; band b occupies bits [b*POT_W +: POT_W].
- audio  input  NUM_BANDS*AUD_W  signed samples; band b occupies bits [b*AUD_W +: AUD_W].
- scaled  output  NUM_BANDS*AUD_W  signed scaled samples, same packing as audio.
- busy  output  1  high from the cycle after an accepted strt until valid.
- valid  output  1  one-cycle pulse: scaled updated with a complete pass.

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; band index, all internal registers, scaled, busy and valid = 0. Reset mid-pass aborts the pass; no partial result is ever presented.
- Capture:
  - strt in IDLE latches POT and audio into input registers on that edge, sets band index = 0, and enters SQR.
  - Inputs may change freely afterwards.
  - strt while busy, or in the valid cycle, is ignored.
- FSM states: IDLE -> SQR -> MUL -> SAT -> (SQR if index < NUM_BANDS-1, else DONE) -> IDLE.
- SQR: sq = POT_b * POT_b (2*POT_W bits, unsigned); register gain = sq[2*POT_W-1 : POT_W].
- MUL:
  - Register product = signed({1'b0, gain}) * audio_b.
  - Product width PW = POT_W+1+AUD_W (29 at defaults).
- SAT:
  - Let H = AUD_W+POT_W-3 (25) and L = POT_W-2 (10).
  - If product[PW-1] = 1 and product[PW-2:H] is not all ones: write 0x8000 (most-negative AUD_W value).
  - If product[PW-1] = 0 and product[PW-2:H] is not all zeros: write 0x7FFF (most-positive).
  - Otherwise write product[H:L]. This is truncation, i.e. floor toward -inf, with no rounding.
  - The result goes to the shadow register for band index; then increment the index.
- DONE:
  - Copy all shadow registers to scaled in one edge; pulse valid for exactly that cycle; busy deasserts in the same cycle.
  - Return to IDLE.
- Latency and throughput:
  - From the strt edge to valid high is 3*NUM_BANDS+1 cycles (16 at default).
  - Minimum strt spacing is 3*NUM_BANDS+2 cycles.
- scaled holds its value between passes and changes only in the valid cycle.
- Gain mapping: POT = 2^(POT_W-1) gives unity gain. Full-scale POT gives about 4x gain (gain 4094 at default).
- Band 0 is processed first; the index wraps only via the DONE/IDLE return. The index never exceeds NUM_BANDS-1.

Test Plan:
- Reset: assert rst_n low mid-pass (cycle 7) -> scaled = 0, busy = 0, valid = 0 immediately; next strt runs a full 16-cycle pass normally.
- Unity and latency: all POT = 0x800, audio = {1000, -1000, 0, 32767, -32768} -> valid exactly 16 cycles after strt; scaled equals the audio inputs exactly; busy high for cycles 1..15.
- Gain path: POT_b = 0xFFF, audio_b = 0x1000 -> scaled_b = 0x3FF8 (gain 4094, 4094*4096>>10 = 16376); POT_b = 0 -> scaled_b = 0.
- Saturation: POT = 0xFFF with audio = 0x2100 -> 0x7FFF; audio = 0xDF00 (-8448) -> 0x8000; audio = 0x1FFF -> no saturation, 0x7FEC. Truncation: POT = 0x800, audio = -1 -> 0xFFFF.
- Handshake: strt re-pulsed at cycles 3 and 16 of a pass -> both ignored; inputs changed after the strt edge -> result reflects captured values; scaled stable until the valid edge, then all bands change together.
- Parameter sweep: NUM_BANDS = 1, 3, 8 and POT_W = 10 with random vectors -> match a reference model (square, shift, multiply, saturate) bit-exactly; valid latency = 3*NUM_BANDS+1.
